// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with a programmable wait-state count before dhit.
// Optional load-reserved/store-conditional support is built when DMEM_LINKED_EN is defined.
module dmem_responder #(
    parameter int          LAT      = 2,
    parameter int          DEPTH    = 1024,
    parameter logic [31:0] INIT_VAL = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        datomic,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        busy,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic           op_store;
    logic [AW-1:0]  op_idx;
    logic [AW-1:0]  req_idx;
    logic           sc_ok;
    logic           mem_we;

    // Power-on content only; reset deliberately leaves the array alone.
    logic [31:0] mem [DEPTH] = '{default: INIT_VAL};

    assign req_idx = dmemaddr[AW+1:2];

`ifdef DMEM_LINKED_EN
    logic          op_atomic;
    logic          resv_valid;
    logic [AW-1:0] resv_idx;
    logic          unused_bits;

    assign sc_ok       = !op_atomic || (resv_valid && (resv_idx == op_idx));
    assign unused_bits = ^dmemaddr[31:AW+2];
`else
    logic unused_bits;

    assign sc_ok       = 1'b1;
    assign unused_bits = ^{datomic, dmemaddr[31:AW+2]};
`endif

    // A reset landing on the RESP edge aborts the store as well.
    assign mem_we = (state == ST_RESP) && op_store && sc_ok && !RST;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[op_idx] <= dmemstore;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            op_store <= 1'b0;
            op_idx   <= '0;
            dhit     <= 1'b0;
            dmemload <= 32'h0;
            busy     <= 1'b0;
            err      <= 1'b0;
`ifdef DMEM_LINKED_EN
            op_atomic  <= 1'b0;
            resv_valid <= 1'b0;
            resv_idx   <= '0;
`endif
        end else begin
            dhit     <= 1'b0;
            dmemload <= 32'h0;
            case (state)
                ST_IDLE: begin
                    if (dmemREN || dmemWEN) begin
                        op_store <= dmemWEN;
                        op_idx   <= req_idx;
                        cnt      <= 4'(LAT);
                        busy     <= 1'b1;
`ifdef DMEM_LINKED_EN
                        op_atomic <= datomic;
`endif
                        if ((dmemaddr[1:0] != 2'b00) || (dmemREN && dmemWEN)) begin
                            err <= 1'b1;
                        end
                        state <= (LAT == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Requester withdrew: drop the access silently.
                    if (!dmemREN && !dmemWEN) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    dhit  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                    if (op_store) begin
                        dmemload <= sc_ok ? 32'h0 : 32'h1;
                    end else begin
                        dmemload <= mem[op_idx];
                    end
`ifdef DMEM_LINKED_EN
                    if (!op_store && op_atomic) begin
                        resv_valid <= 1'b1;
                        resv_idx   <= op_idx;
                    end else if (op_store && (op_atomic || (op_idx == resv_idx))) begin
                        resv_valid <= 1'b0;
                    end
`endif
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LAT=2 and a LAT=0 instance checked against a word-array model.
// Build with DMEM_LINKED_EN defined to include the LR/SC sequence.
module tb_dmem_responder;

    localparam int          DEPTH    = 1024;
    localparam logic [31:0] INIT_VAL = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        ren, wen, atomic, sel;
    logic [31:0] addr, wdata;

    logic        ren2, wen2, ren0, wen0;
    logic        dhit2, busy2, err2, dhit0, busy0, err0;
    logic [31:0] load2, load0;
    logic        dhit_s, busy_s, err_s;
    logic [31:0] load_s;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem2 [int];
    logic [31:0] mem0 [int];
    bit          err_exp [2];
    bit          resv_v;
    int          resv_i;

    assign ren2   = ren & ~sel;
    assign wen2   = wen & ~sel;
    assign ren0   = ren & sel;
    assign wen0   = wen & sel;
    assign dhit_s = sel ? dhit0 : dhit2;
    assign busy_s = sel ? busy0 : busy2;
    assign err_s  = sel ? err0  : err2;
    assign load_s = sel ? load0 : load2;

    always #5 clk = ~clk;

    dmem_responder #(.LAT(2), .DEPTH(DEPTH), .INIT_VAL(INIT_VAL)) u_dut2 (
        .CLK(clk), .RST(rst), .dmemREN(ren2), .dmemWEN(wen2), .dmemaddr(addr),
        .dmemstore(wdata), .datomic(atomic), .dhit(dhit2), .dmemload(load2),
        .busy(busy2), .err(err2)
    );

    dmem_responder #(.LAT(0), .DEPTH(DEPTH), .INIT_VAL(INIT_VAL)) u_dut0 (
        .CLK(clk), .RST(rst), .dmemREN(ren0), .dmemWEN(wen0), .dmemaddr(addr),
        .dmemstore(wdata), .datomic(atomic), .dhit(dhit0), .dmemload(load0),
        .busy(busy0), .err(err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] mread(input bit s, input int i);
        if (s) return mem0.exists(i) ? mem0[i] : INIT_VAL;
        return mem2.exists(i) ? mem2[i] : INIT_VAL;
    endfunction

    task automatic do_reset(input string tag);
        rst = 1'b1; ren = 1'b0; wen = 1'b0; atomic = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        err_exp[0] = 1'b0;
        err_exp[1] = 1'b0;
        resv_v = 1'b0;
        check({tag, " dhit2"}, dhit2, 0);
        check({tag, " busy2"}, busy2, 0);
        check({tag, " err2"},  err2, 0);
        check({tag, " load2"}, load2, 0);
        check({tag, " dhit0"}, dhit0, 0);
        check({tag, " err0"},  err0, 0);
    endtask

    // One full request: drive, wait for dhit (bounded), compare, release.
    task automatic access(input bit r, input bit w, input bit at, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        int          lat;
        int          i;
        int          cyc;
        bit          got;
        bit          do_write;
        logic [31:0] exp_load;
        lat      = sel ? 0 : 2;
        i        = widx(a);
        do_write = w;
        exp_load = w ? 32'h0 : mread(sel, i);
`ifdef DMEM_LINKED_EN
        if (!sel) begin
            if (w && at) begin
                if (resv_v && resv_i == i) exp_load = 32'h0;
                else begin
                    exp_load = 32'h1;
                    do_write = 1'b0;
                end
                resv_v = 1'b0;
            end else if (w && resv_i == i) begin
                resv_v = 1'b0;
            end else if (r && !w && at) begin
                resv_v = 1'b1;
                resv_i = i;
            end
        end
`endif
        if (a[1:0] != 2'b00 || (r && w)) err_exp[sel] = 1'b1;
        ren = r; wen = w; atomic = at; addr = a; wdata = d;
        @(posedge clk);
        cyc = 0;
        got = 1'b0;
        while (cyc < 20) begin
            @(negedge clk);
            if (dhit_s) begin
                got = 1'b1;
                break;
            end
            check({tag, " busy_wait"}, busy_s, 1);
            @(posedge clk);
            cyc++;
        end
        check({tag, " dhit_seen"}, got, 1);
        check({tag, " latency"}, cyc, lat + 1);
        check({tag, " load"}, load_s, exp_load);
        check({tag, " busy_done"}, busy_s, 0);
        check({tag, " err"}, err_s, err_exp[sel]);
        ren = 1'b0; wen = 1'b0; atomic = 1'b0;
        if (do_write) begin
            if (sel) mem0[i] = d;
            else mem2[i] = d;
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, " dhit_pulse"}, dhit_s, 0);
        check({tag, " load_idle"}, load_s, 0);
    endtask

    task automatic random_ops(input int n, input string tag);
        int          k;
        logic [31:0] a;
        for (int j = 0; j < n; j++) begin
            k = $urandom_range(0, 9);
            a = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            if (k < 5) access(1'b1, 1'b0, 1'b0, a, 32'h0, tag);
            else if (k < 9) access(1'b0, 1'b1, 1'b0, a, $urandom(), tag);
            else access(1'b1, 1'b1, 1'b0, a, $urandom(), tag);
        end
    endtask

    initial begin
        rst = 1'b1; ren = 1'b0; wen = 1'b0; atomic = 1'b0; sel = 1'b0;
        addr = 32'h0; wdata = 32'h0; resv_v = 1'b0; resv_i = 0;
        @(posedge clk);
        do_reset("reset");

        access(1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, "sw_100");
        access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, "lw_100");
        access(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, "lw_init");
        access(1'b0, 1'b1, 1'b0, 32'h4, 32'h11112222, "sw_4");
        access(1'b1, 1'b0, 1'b0, 32'h1004, 32'h0, "lw_wrap");

        // Reset lands while a store is waiting: nothing may be written.
        access(1'b0, 1'b1, 1'b0, 32'h20, 32'hAAAA5555, "sw_20");
        ren = 1'b0; wen = 1'b1; addr = 32'h20; wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        check("rstwait busy_before", busy2, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; wen = 1'b0;
        err_exp[0] = 1'b0; err_exp[1] = 1'b0; resv_v = 1'b0;
        check("rstwait busy_after", busy2, 0);
        check("rstwait dhit_after", dhit2, 0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("rstwait no_dhit", dhit2, 0);
        end
        access(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, "lw_20_kept");

        // Requester drops WEN mid-wait.
        ren = 1'b0; wen = 1'b1; addr = 32'h30; wdata = 32'h00000077;
        @(posedge clk);
        @(negedge clk);
        check("abort busy_before", busy2, 1);
        wen = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort busy_after", busy2, 0);
        check("abort dhit_after", dhit2, 0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("abort no_dhit", dhit2, 0);
        end
        access(1'b1, 1'b0, 1'b0, 32'h30, 32'h0, "lw_30_unwritten");

        access(1'b1, 1'b1, 1'b0, 32'h8, 32'hCAFEF00D, "renwen_8");
        access(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, "lw_8_sticky");
        do_reset("reset_err");
        access(1'b1, 1'b0, 1'b0, 32'h102, 32'h0, "lw_misalign");
        access(1'b0, 1'b1, 1'b0, 32'h10A, 32'h0BADF00D, "sw_misalign");
        access(1'b1, 1'b0, 1'b0, 32'h108, 32'h0, "lw_108");
        do_reset("reset_pre_lat0");

        sel = 1'b1;
        access(1'b0, 1'b1, 1'b0, 32'h100, 32'h00000055, "lat0_sw");
        access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, "lat0_lw");
        access(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, "lat0_lw_init");
        random_ops(15, "lat0_rand");

        sel = 1'b0;
        random_ops(30, "lat2_rand");

`ifdef DMEM_LINKED_EN
        do_reset("reset_lrsc");
        access(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, "lr_40");
        access(1'b0, 1'b1, 1'b1, 32'h40, 32'h5, "sc_40_ok");
        access(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, "lw_40_5");
        access(1'b0, 1'b1, 1'b1, 32'h40, 32'h9, "sc_40_fail");
        access(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, "lw_40_still5");
        access(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, "lr_40_again");
        access(1'b0, 1'b1, 1'b0, 32'h40, 32'h7, "sw_40_plain");
        access(1'b0, 1'b1, 1'b1, 32'h40, 32'h8, "sc_40_after_sw");
        access(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, "lw_40_7");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
